// File: rtl/cam_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
// Shared definitions for the camera stream generator:
//   state_t         frame sequencer states
//   PAT_*           pattern_sel codes (solid, horizontal ramp, vertical ramp,
//                   checkerboard)
//   CHROMA_NEUTRAL  chroma byte sent as byte0 of every pixel
// -----------------------------------------------------------------------------
package cam_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } state_t;

    localparam logic [1:0] PAT_SOLID = 2'd0;
    localparam logic [1:0] PAT_HRAMP = 2'd1;
    localparam logic [1:0] PAT_VRAMP = 2'd2;
    localparam logic [1:0] PAT_CHECK = 2'd3;

    localparam logic [7:0] CHROMA_NEUTRAL = 8'h80;

endpackage

// File: rtl/cam_pattern_gen.sv
// -----------------------------------------------------------------------------
// cam_pattern_gen
// Combinational test-pattern luma generator.
// Ports:
//   x     in  8  low byte of the pixel column
//   y     in  8  low byte of the active line index
//   sel   in  2  pattern code (PAT_SOLID/PAT_HRAMP/PAT_VRAMP/PAT_CHECK)
//   gray  in  8  luma used by the solid pattern
//   luma  out 8  luma byte for this pixel
// Only the low byte of each coordinate affects any pattern, so the upper
// coordinate bits are not brought into this block.
// -----------------------------------------------------------------------------
module cam_pattern_gen
    import cam_pkg::*;
(
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [1:0] sel,
    input  logic [7:0] gray,
    output logic [7:0] luma
);

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        luma = gray;
        case (sel)
            PAT_SOLID: luma = gray;
            PAT_HRAMP: luma = x;
            PAT_VRAMP: luma = y;
            PAT_CHECK: luma = (x[5] ^ y[5]) ? 8'hFF : 8'h00;
            default:   luma = gray;
        endcase
    end

endmodule

// File: rtl/cam_stream_gen.sv
// -----------------------------------------------------------------------------
// cam_stream_gen
// OV7670-style YUYV camera stream source (one byte per cam_pclk). Each pixel
// is two bytes: chroma 0x80, then luma from the selected test pattern.
// Ports:
//   cam_pclk     in   1   pixel clock, all logic on posedge
//   reset        in   1   synchronous, active-low
//   enable       in   1   stream frames; sampled in IDLE and at frame end
//   pattern_sel  in   2   pattern code, latched at frame start
//   gray_level   in   8   solid-pattern luma, latched at frame start
//   cam_vs       out  1   vertical sync, active-high
//   cam_href     out  1   line valid
//   cam_byte     out  8   data byte, 0x00 while cam_href=0
//   frame_start  out  1   pulse on the first cam_vs=1 cycle of a frame
//   frame_cnt    out  16  completed frames, wrapping
// Build option CAM_GEN_FRAME_TAG_EN: luma of pixels (0,0) and (1,0) carry
// frame_cnt[7:0] and frame_cnt[15:8] as sampled at frame start.
// -----------------------------------------------------------------------------
module cam_stream_gen
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 288,
    parameter int VS_LINES = 3,
    parameter int V_BACK   = 17,
    parameter int V_FRONT  = 10
) (
    input  logic        cam_pclk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [7:0]  gray_level,
    output logic        cam_vs,
    output logic        cam_href,
    output logic [7:0]  cam_byte,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int HREF_LEN = 2 * H_ACTIVE;
    localparam int LINE_LEN = HREF_LEN + H_BLANK;

    state_t      state;
    logic [10:0] byte_cnt;
    logic [10:0] line_cnt;
    logic [10:0] state_lines;
    logic [1:0]  pat_q;
    logic [7:0]  gray_q;
    logic        line_end;
    logic        state_end;
    logic        frame_end;
    logic        in_href;
    logic [7:0]  pattern_luma;
    logic [7:0]  luma;

    always_comb begin
        state_lines = 11'd1;
        case (state)
            VSYNC:   state_lines = 11'(VS_LINES);
            VBACK:   state_lines = 11'(V_BACK);
            ACTIVE:  state_lines = 11'(V_ACTIVE);
            VFRONT:  state_lines = 11'(V_FRONT);
            default: state_lines = 11'd1;
        endcase
    end

    assign line_end  = (byte_cnt == 11'(LINE_LEN - 1));
    assign state_end = line_end && (line_cnt == state_lines - 11'd1);
    assign frame_end = (state == VFRONT) && state_end;
    assign in_href   = (state == ACTIVE) && (byte_cnt < 11'(HREF_LEN));

    // In ACTIVE, line_cnt is the active line index and byte_cnt>>1 the column.
    cam_pattern_gen u_pattern (
        .x    (byte_cnt[8:1]),
        .y    (line_cnt[7:0]),
        .sel  (pat_q),
        .gray (gray_q),
        .luma (pattern_luma)
    );

`ifdef CAM_GEN_FRAME_TAG_EN
    logic [15:0] tag_q;

    always_comb begin
        luma = pattern_luma;
        if (line_cnt == 11'd0 && byte_cnt[10:1] == 10'd0)
            luma = tag_q[7:0];
        else if (line_cnt == 11'd0 && byte_cnt[10:1] == 10'd1)
            luma = tag_q[15:8];
    end
`else
    assign luma = pattern_luma;
`endif

    // Outputs are registered from the current position, so they trail the
    // sequencer by one edge: the edge that leaves IDLE shows its first VSYNC
    // cycle on the following edge.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register in this block sees pre-edge values of the others.
    always_ff @(posedge cam_pclk) begin
        if (!reset) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            line_cnt    <= '0;
            pat_q       <= PAT_SOLID;
            gray_q      <= '0;
            cam_vs      <= 1'b0;
            cam_href    <= 1'b0;
            cam_byte    <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
`ifdef CAM_GEN_FRAME_TAG_EN
            tag_q       <= '0;
`endif
        end else begin
            cam_vs      <= (state == VSYNC);
            frame_start <= (state == VSYNC) && (byte_cnt == 11'd0) && (line_cnt == 11'd0);
            cam_href    <= in_href;
            cam_byte    <= !in_href ? 8'h00 : (byte_cnt[0] ? luma : CHROMA_NEUTRAL);
            if (frame_end)
                frame_cnt <= frame_cnt + 16'd1;

            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= VSYNC;
                        byte_cnt <= '0;
                        line_cnt <= '0;
                        pat_q    <= pattern_sel;
                        gray_q   <= gray_level;
`ifdef CAM_GEN_FRAME_TAG_EN
                        tag_q    <= frame_cnt;
`endif
                    end
                end
                default: begin
                    byte_cnt <= line_end ? 11'd0 : byte_cnt + 11'd1;
                    if (state_end) begin
                        line_cnt <= '0;
                        case (state)
                            VSYNC:  state <= VBACK;
                            VBACK:  state <= ACTIVE;
                            ACTIVE: state <= VFRONT;
                            default: begin
                                if (enable) begin
                                    state  <= VSYNC;
                                    pat_q  <= pattern_sel;
                                    gray_q <= gray_level;
`ifdef CAM_GEN_FRAME_TAG_EN
                                    // frame_cnt increments on this same edge.
                                    tag_q  <= frame_cnt + 16'd1;
`endif
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        endcase
                    end else if (line_end) begin
                        line_cnt <= line_cnt + 11'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_stream_gen.sv
// -----------------------------------------------------------------------------
// tb_cam_stream_gen
// Scoreboard bench: the stimulus process computes each frame's full expected
// byte stream from the frame-timing arithmetic and queues it; a monitor pops
// one entry per cycle and compares (idle outputs when the queue is empty).
// -----------------------------------------------------------------------------
module tb_cam_stream_gen;

    localparam int H_ACTIVE = 8;
    localparam int V_ACTIVE = 4;
    localparam int H_BLANK  = 4;
    localparam int VS_LINES = 1;
    localparam int V_BACK   = 1;
    localparam int V_FRONT  = 1;
    localparam int L        = 2 * H_ACTIVE + H_BLANK;
    localparam int FRAME    = (VS_LINES + V_BACK + V_ACTIVE + V_FRONT) * L;
    localparam int NF       = 10;

`ifdef CAM_GEN_FRAME_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    typedef struct packed {
        logic        vs;
        logic        href;
        logic        fs;
        logic [7:0]  data;
        logic [15:0] cnt;
    } obs_t;

    logic        cam_pclk    = 1'b0;
    logic        reset       = 1'b0;
    logic        enable      = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [7:0]  gray_level  = 8'd0;
    logic        cam_vs;
    logic        cam_href;
    logic [7:0]  cam_byte;
    logic        frame_start;
    logic [15:0] frame_cnt;

    logic [7:0]  pg_x = 8'd0;
    logic [7:0]  pg_y = 8'd0;
    logic [1:0]  pg_sel = 2'd0;
    logic [7:0]  pg_gray = 8'd0;
    logic [7:0]  pg_luma;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 cam_pclk = ~cam_pclk;

    cam_stream_gen #(
        .H_ACTIVE (H_ACTIVE), .V_ACTIVE (V_ACTIVE), .H_BLANK (H_BLANK),
        .VS_LINES (VS_LINES), .V_BACK   (V_BACK),   .V_FRONT (V_FRONT)
    ) dut (
        .cam_pclk    (cam_pclk),
        .reset       (reset),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .gray_level  (gray_level),
        .cam_vs      (cam_vs),
        .cam_href    (cam_href),
        .cam_byte    (cam_byte),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    // Coordinates up to 255 are not reachable with the small frame above,
    // so the pattern block is also exercised directly.
    cam_pattern_gen pg (
        .x (pg_x), .y (pg_y), .sel (pg_sel), .gray (pg_gray), .luma (pg_luma)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    function automatic logic [7:0] pat_luma(input int pat, input int gray, input int x, input int y);
        case (pat)
            0:       return 8'(gray);
            1:       return 8'(x % 256);
            2:       return 8'(y % 256);
            default: return (((x / 32) % 2) != ((y / 32) % 2)) ? 8'hFF : 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] ref_luma(input int pat, input int gray, input int x, input int y, input int cnt);
        if (TAG_EN && y == 0 && x == 0) return 8'(cnt % 256);
        if (TAG_EN && y == 0 && x == 1) return 8'((cnt / 256) % 256);
        return pat_luma(pat, gray, x, y);
    endfunction

    // Expected stream of one whole frame, starting with its first cam_vs cycle.
    task automatic push_frame(input int pat, input int gray, input int cnt);
        for (int t = 0; t < FRAME; t++) begin
            obs_t r;
            int   line, b, al;
            line  = t / L;
            b     = t % L;
            al    = line - VS_LINES - V_BACK;
            r     = '0;
            r.vs  = (line < VS_LINES);
            r.fs  = (t == 0);
            r.cnt = (t == FRAME - 1) ? 16'((cnt + 1) % 65536) : 16'(cnt);
            if (al >= 0 && al < V_ACTIVE && b < 2 * H_ACTIVE) begin
                r.href = 1'b1;
                r.data = (b % 2 == 1) ? ref_luma(pat, gray, b / 2, al, cnt) : 8'h80;
            end
            exp_q.push_back(r);
        end
    endtask

    task automatic push_idle(input int cnt);
        obs_t r;
        r     = '0;
        r.cnt = 16'(cnt);
        exp_q.push_back(r);
    endtask

    // Monitor: one comparison per clock, sampled 1 ns after the rising edge.
    initial begin
        obs_t idle_exp;
        obs_t act;
        obs_t e;
        idle_exp = '0;
        repeat (2) @(posedge cam_pclk);
        forever begin
            @(posedge cam_pclk);
            #1;
            act = {cam_vs, cam_href, frame_start, cam_byte, frame_cnt};
            if (exp_q.size() > 0) begin
                e            = exp_q.pop_front();
                idle_exp     = '0;
                idle_exp.cnt = e.cnt;
                check("stream", {5'd0, act}, {5'd0, e});
            end else begin
                check("idle", {5'd0, act}, {5'd0, idle_exp});
            end
        end
    end

    // Stimulus
    initial begin
        int  pats[NF]     = '{1, 3, 0, 2, 1, 2, 3, 0, 1, 2};
        bit  keep[NF]     = '{1, 1, 0, 0, 1, 0, 1, 1, 1, 0};
        int  abort_at[NF] = '{0, 0, 0, 70, 0, 0, 0, 0, 0, 0};
        int  cpx[4]       = '{0, 32, 0, 32};
        int  cpy[4]       = '{0, 0, 32, 32};
        int  model_cnt;
        bit  streaming;

        // Checkerboard corner points, then random pattern points.
        for (int k = 0; k < 28; k++) begin
            int xr, yr, sr, gr;
            if (k < 4) begin
                xr = cpx[k]; yr = cpy[k]; sr = 3; gr = 0;
            end else begin
                xr = int'($urandom_range(2047)); yr = int'($urandom_range(2047));
                sr = int'($urandom_range(3));    gr = int'($urandom_range(255));
            end
            pg_x = 8'(xr); pg_y = 8'(yr); pg_sel = 2'(sr); pg_gray = 8'(gr);
            #1;
            check("pattern", {24'd0, pg_luma}, {24'd0, pat_luma(sr, gr, xr, yr)});
        end

        reset = 1'b0;
        repeat (3) @(negedge cam_pclk);
        reset     = 1'b1;
        model_cnt = 0;
        streaming = 1'b0;

        for (int f = 0; f < NF; f++) begin
            if (!streaming) begin
                repeat (12) @(negedge cam_pclk);
                pattern_sel = 2'(pats[f]);
                gray_level  = (f == 2) ? 8'h55 : 8'($urandom_range(255));
                enable      = 1'b1;
                push_idle(model_cnt);
                push_frame(pats[f], int'(gray_level), model_cnt);
            end
            for (int i = 1; i <= FRAME; i++) begin
                @(negedge cam_pclk);
                if (i == abort_at[f]) begin
                    reset  = 1'b0;
                    enable = 1'b0;
                    exp_q.delete();
                    push_idle(0);
                    repeat (2) @(negedge cam_pclk);
                    reset     = 1'b1;
                    model_cnt = 0;
                    streaming = 1'b0;
                    break;
                end
                if (i < FRAME) begin
                    if (i == 40)
                        pattern_sel = pattern_sel ^ 2'b01;
                    if ($urandom_range(15) == 0) begin
                        pattern_sel = 2'($urandom_range(3));
                        gray_level  = 8'($urandom_range(255));
                    end
                    if (f == 2 && i >= 65)
                        enable = 1'b0;
                    else if ($urandom_range(7) == 0)
                        enable = 1'($urandom_range(1));
                end else begin
                    model_cnt = (model_cnt + 1) % 65536;
                    enable    = keep[f];
                    streaming = keep[f];
                    if (keep[f] && f + 1 < NF) begin
                        pattern_sel = 2'(pats[f + 1]);
                        gray_level  = 8'($urandom_range(255));
                        push_frame(pats[f + 1], int'(gray_level), model_cnt);
                    end
                end
            end
        end

        repeat (10) @(negedge cam_pclk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
